dmem_lsu: RTL and testbench

- Parametrised, byte-addressable RV32 data memory with a request/response handshake and configurable access latency.
- Supports the full RISC-V load/store width set: LB/LH/LW/LBU/LHU and SB/SH/SW.
  - Byte-lane merging on stores.
  - Sign/zero extension on loads.
- Flags misaligned and illegal accesses.
- Sits between the core's memory stage and the word array; it is the multicycle-ready replacement for the flat single-cycle data memory.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_lsu_align.sv | 85 ++++++++
 rtl/dmem_lsu.sv | 127 ++++++++++++
 tb/tb_dmem_lsu.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable RV32 data memory: funct3 codes and FSM states.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: store byte enables and replicated data, load extraction/extension,
// misalignment and illegal-funct3 detection.
module dmem_lsu_align
   import dmem_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            we,
   input  logic [2:0]      funct3,
   input  logic [1:0]      lane,
   input  logic            oob,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rword,
   output logic [3:0]      be_c,
   output logic [XLEN-1:0] wdata_c,
   output logic [XLEN-1:0] rdata_c,
   output logic            err_c
);

   logic       illegal_c;
   logic       misalign_c;
   logic [7:0] byte_c;
   logic [15:0] half_c;

   // Fault classification; any fault suppresses both the write and the load data.
   always_comb begin
      illegal_c  = 1'b0;
      misalign_c = 1'b0;
      case (funct3)
         F3_B:         illegal_c  = 1'b0;
         F3_H:         misalign_c = lane[0];
         F3_W:         misalign_c = (lane != 2'd0);
         F3_BU:        illegal_c  = we;
         F3_HU: begin
            illegal_c  = we;
            misalign_c = lane[0];
         end
         default:      illegal_c  = 1'b1;
      endcase
      err_c = illegal_c | misalign_c | oob;
   end

   // Store data is replicated across lanes so the byte enables alone select the target.
   always_comb begin
      be_c    = 4'b0000;
      wdata_c = wdata;
      case (funct3)
         F3_B: begin
            be_c    = 4'b0001 << lane;
            wdata_c = {4{wdata[7:0]}};
         end
         F3_H: begin
            be_c    = 4'b0011 << {lane[1], 1'b0};
            wdata_c = {2{wdata[15:0]}};
         end
         F3_W:    be_c = 4'b1111;
         default: be_c = 4'b0000;
      endcase
      if (!we || err_c) be_c = 4'b0000;
   end

   always_comb begin
      case (lane)
         2'd0:    byte_c = rword[7:0];
         2'd1:    byte_c = rword[15:8];
         2'd2:    byte_c = rword[23:16];
         default: byte_c = rword[31:24];
      endcase
      half_c = lane[1] ? rword[31:16] : rword[15:0];
   end

   always_comb begin
      rdata_c = '0;
      case (funct3)
         F3_B:    rdata_c = {{(XLEN-8){byte_c[7]}}, byte_c};
         F3_H:    rdata_c = {{(XLEN-16){half_c[15]}}, half_c};
         F3_W:    rdata_c = rword;
         F3_BU:   rdata_c = {{(XLEN-8){1'b0}}, byte_c};
         F3_HU:   rdata_c = {{(XLEN-16){1'b0}}, half_c};
         default: rdata_c = '0;
      endcase
      if (we || err_c) rdata_c = '0;
   end

endmodule

// File: rtl/dmem_lsu.sv
// RV32 data memory with request/response handshake and LATENCY wait cycles.
// Optional DMEM_BOUNDS_CHECK_EN faults addresses beyond the array instead of aliasing them.
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t          state, state_n;
   logic [CW-1:0]   cnt;
   logic            accept_c, access_c;
   logic            we_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] addr_q, wdata_q;
   logic [XLEN-1:0] res_rdata;
   logic            res_err;
   logic [XLEN-1:0] mem [DEPTH_WORDS];
   logic [AW-1:0]   idx_c;
   logic            oob_c;
   logic [3:0]      be_c;
   logic [XLEN-1:0] wsh_c, rdata_c;
   logic            err_c;

   assign idx_c = addr_q[AW+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
   assign oob_c = ((addr_q >> (AW + 2)) != '0);
`else
   logic unused_hi;
   assign unused_hi = ^(addr_q >> (AW + 2));
   assign oob_c     = 1'b0;
`endif

   dmem_lsu_align #(.XLEN(XLEN)) u_align (
      .we      (we_q),
      .funct3  (f3_q),
      .lane    (addr_q[1:0]),
      .oob     (oob_c),
      .wdata   (wdata_q),
      .rword   (mem[idx_c]),
      .be_c    (be_c),
      .wdata_c (wsh_c),
      .rdata_c (rdata_c),
      .err_c   (err_c)
   );

   always_comb begin
      state_n  = state;
      accept_c = 1'b0;
      access_c = 1'b0;
      case (state)
         S_IDLE: if (req_valid && req_ready) begin
            accept_c = 1'b1;
            state_n  = S_WAIT;
         end
         S_WAIT: if (cnt == '0) begin
            access_c = 1'b1;
            state_n  = S_RESP;
         end
         S_RESP:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Control state; the response is registered out of RESP, so it lands one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_n;
         req_ready <= (state_n == S_IDLE);
         rsp_valid <= (state == S_RESP);
         if (accept_c)
            cnt <= CW'(LATENCY - 1);
         else if (state == S_WAIT && cnt != '0)
            cnt <= cnt - CW'(1);
         if (state == S_RESP) begin
            rsp_rdata <= res_rdata;
            rsp_err   <= res_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept_c) begin
         we_q    <= req_we;
         f3_q    <= req_funct3;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
      if (access_c) begin
         res_rdata <= rdata_c;
         res_err   <= err_c;
      end
   end

   // Array is not reset; a reset on the access edge cancels the write.
   always_ff @(posedge clk) begin
      if (access_c && !rst) begin
         for (int i = 0; i < 4; i++)
            if (be_c[i]) mem[idx_c][8*i +: 8] <= wsh_c[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with hand-computed expectations; honours DMEM_BOUNDS_CHECK_EN.
module tb_dmem_lsu;

   localparam int unsigned LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int nvec = 0;
   int nerr = 0;

   dmem_lsu #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One full transaction: wait for ready, accept, then check latency, data, error and pulse width.
   task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
      int n;
      bit seen;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check({tag, "_ready"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (rsp_valid) seen = 1'b1;
      end
      check({tag, "_lat"}, 32'(n), 32'(LAT + 1));
      check({tag, "_rdata"}, rsp_rdata, exp_rd);
      check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      @(posedge clk);
      #1 check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = '0;
      req_wdata  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", 32'(rsp_err), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1 check("ready_after_rst", 32'(req_ready), 32'd1);

      xact("sw100",  1'b1, 3'd2, 32'h100, 32'h8899AABB, 32'h0, 1'b0);
      xact("lw100",  1'b0, 3'd2, 32'h100, 32'h0, 32'h8899AABB, 1'b0);

      xact("sw100b", 1'b1, 3'd2, 32'h100, 32'h11223344, 32'h0, 1'b0);
      xact("sb101",  1'b1, 3'd0, 32'h101, 32'h000000FF, 32'h0, 1'b0);
      xact("lw100b", 1'b0, 3'd2, 32'h100, 32'h0, 32'h1122FF44, 1'b0);
      xact("lb101",  1'b0, 3'd0, 32'h101, 32'h0, 32'hFFFFFFFF, 1'b0);
      xact("lbu101", 1'b0, 3'd4, 32'h101, 32'h0, 32'h000000FF, 1'b0);

      xact("sh102",  1'b1, 3'd1, 32'h102, 32'h00008001, 32'h0, 1'b0);
      xact("lh102",  1'b0, 3'd1, 32'h102, 32'h0, 32'hFFFF8001, 1'b0);
      xact("lhu102", 1'b0, 3'd5, 32'h102, 32'h0, 32'h00008001, 1'b0);
      xact("lh100",  1'b0, 3'd1, 32'h100, 32'h0, 32'hFFFFFF44, 1'b0);
      xact("lb100",  1'b0, 3'd0, 32'h100, 32'h0, 32'h00000044, 1'b0);
      xact("lw100c", 1'b0, 3'd2, 32'h100, 32'h0, 32'h8001FF44, 1'b0);

      xact("sw104",  1'b1, 3'd2, 32'h104, 32'hCAFEF00D, 32'h0, 1'b0);
      xact("lw103",  1'b0, 3'd2, 32'h103, 32'h0, 32'h0, 1'b1);
      xact("sh105",  1'b1, 3'd1, 32'h105, 32'h00001234, 32'h0, 1'b1);
      xact("sbu104", 1'b1, 3'd4, 32'h104, 32'h00000000, 32'h0, 1'b1);
      xact("f3_3",   1'b0, 3'd3, 32'h104, 32'h0, 32'h0, 1'b1);
      xact("lw104",  1'b0, 3'd2, 32'h104, 32'h0, 32'hCAFEF00D, 1'b0);

      // Reset while the store is waiting: no write and no response.
      xact("sw200",  1'b1, 3'd2, 32'h200, 32'h11111111, 32'h0, 1'b0);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = 32'h200;
      req_wdata  = 32'hDEADBEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 check("midrst_novalid", 32'(rsp_valid), 32'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) check("midrst_ready", 32'(req_ready), 32'd1);
         check("postrst_novalid", 32'(rsp_valid), 32'd0);
      end
      xact("lw200",  1'b0, 3'd2, 32'h200, 32'h0, 32'h11111111, 1'b0);

      xact("sw0",    1'b1, 3'd2, 32'h0, 32'h01020304, 32'h0, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
      xact("sw1000", 1'b1, 3'd2, 32'h1000, 32'hA5A5A5A5, 32'h0, 1'b1);
      xact("lw1000", 1'b0, 3'd2, 32'h1000, 32'h0, 32'h0, 1'b1);
      xact("lw0",    1'b0, 3'd2, 32'h0, 32'h0, 32'h01020304, 1'b0);
`else
      xact("sw1000", 1'b1, 3'd2, 32'h1000, 32'hA5A5A5A5, 32'h0, 1'b0);
      xact("lw0",    1'b0, 3'd2, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
